// File: rtl/ps2_pkg.sv
// Shared PS/2 host-transmit definitions: FSM states, frame size,
// default timing and common keyboard command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        ACK,
        WAIT_IDLE,
        DONE
    } state_t;

    localparam int FRAME_BITS = 10;

    localparam int DEF_INHIBIT_CYCLES = 5000;
    localparam int DEF_REQ_CYCLES     = 50;
    localparam int DEF_FILTER_LEN     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 750000;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    // LSB-first frame: data, odd parity, stop
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [7:0] b
    );
        return {1'b1, ~^b, b};
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side bundle of the PS/2 host transmitter.
// master issues commands, slave is the transmitter.
interface ps2_host_tx_if;

    logic       start;
    logic [7:0] din;
    logic       busy;
    logic       rx_inhibit;
    logic       done_tick;
    logic       ack_ok;
    logic       err_timeout;

    modport master (
        output start, din,
        input  busy, rx_inhibit, done_tick,
        input  ack_ok, err_timeout
    );

    modport slave (
        input  start, din,
        output busy, rx_inhibit, done_tick,
        output ack_ok, err_timeout
    );

endinterface

// File: rtl/ps2_clk_filter.sv
// PS/2 clock synchronizer and debounce filter with a one-cycle
// fall pulse; shared by the host-transmit and receive paths.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2c_in,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], ps2c_in};
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // old level 1 flipping to 0 is a fall
                cnt   <= '0;
                level <= sync[1];
                fall  <= level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain
// clock/data enables and checking the device acknowledge.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int REQ_CYCLES     = DEF_REQ_CYCLES,
    parameter int FILTER_LEN     = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic          clk,
    input  logic          rst,
    ps2_host_tx_if.slave  bus,
    input  logic          ps2c_in,
    input  logic          ps2d_in,
    output logic          ps2c_oe,
    output logic          ps2d_oe
);

    localparam int PMAX = (INHIBIT_CYCLES > REQ_CYCLES) ?
                          INHIBIT_CYCLES : REQ_CYCLES;
    localparam int PW = $clog2(PMAX) + 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int BW = $clog2(FRAME_BITS) + 1;

    localparam logic [PW-1:0] INH_LAST = PW'(INHIBIT_CYCLES - 1);
    localparam logic [PW-1:0] REQ_LAST = PW'(REQ_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

    state_t                state, state_nx;
    logic [PW-1:0]         cnt;
    logic [WW-1:0]         wd;
    logic [BW-1:0]         bit_cnt;
    logic [FRAME_BITS-1:0] frame;
    logic                  d_bit;
    logic [1:0]            d_sync;
    logic                  c_level, c_fall;
    logic                  ack_r, tmo_r;
    logic                  start_ok, inh_end, req_end;
    logic                  watched, wd_exp;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
        .clk     (clk),
        .rst     (rst),
        .ps2c_in (ps2c_in),
        .level   (c_level),
        .fall    (c_fall)
    );

    assign start_ok = (state == IDLE) && bus.start;
    assign inh_end  = (cnt == INH_LAST);
    assign req_end  = (cnt == REQ_LAST);
    assign watched  = state inside {DATA, ACK, WAIT_IDLE};
    assign wd_exp   = watched && (wd == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // watchdog expiry outranks a coincident fall
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (bus.start) state_nx = INHIBIT;
            INHIBIT:   if (inh_end) state_nx = REQ;
            REQ:       if (req_end) state_nx = DATA;
            DATA:
                if (wd_exp) state_nx = DONE;
                else if (c_fall && bit_cnt == BIT_LAST)
                    state_nx = ACK;
            ACK:
                if (wd_exp)      state_nx = DONE;
                else if (c_fall) state_nx = WAIT_IDLE;
            WAIT_IDLE:
                if (wd_exp) state_nx = DONE;
                else if (c_level && d_sync[1])
                    state_nx = DONE;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        ps2c_oe       = 1'b0;
        ps2d_oe       = 1'b0;
        bus.busy      = 1'b1;
        bus.done_tick = 1'b0;
        unique case (state)
            IDLE:    bus.busy = 1'b0;
            INHIBIT: ps2c_oe = 1'b1;
            REQ: begin
                ps2c_oe = 1'b1;
                ps2d_oe = 1'b1;
            end
            DATA:    ps2d_oe = d_bit;
            DONE: begin
                bus.busy      = 1'b0;
                bus.done_tick = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.rx_inhibit  = bus.busy;
    assign bus.ack_ok      = ack_r;
    assign bus.err_timeout = tmo_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            wd      <= '0;
            bit_cnt <= '0;
            frame   <= '0;
            d_bit   <= 1'b0;
            d_sync  <= '0;
            ack_r   <= 1'b0;
            tmo_r   <= 1'b0;
        end else begin
            d_sync <= {d_sync[0], ps2d_in};
            if (start_ok) begin
                frame <= build_frame(bus.din);
                cnt   <= '0;
                ack_r <= 1'b0;
                tmo_r <= 1'b0;
            end
            if (state == INHIBIT)
                cnt <= inh_end ? '0 : cnt + PW'(1);
            if (state == REQ) begin
                cnt <= cnt + PW'(1);
                if (req_end) begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    wd      <= '0;
                    d_bit   <= 1'b1;
                end
            end
            if (watched) begin
                wd <= wd + WW'(1);
                if (wd_exp) begin
                    tmo_r <= 1'b1;
                    ack_r <= 1'b0;
                end else if (c_fall && state == DATA) begin
                    d_bit   <= ~frame[bit_cnt[BW-2:0]];
                    bit_cnt <= bit_cnt + BW'(1);
                end else if (c_fall && state == ACK) begin
                    ack_r <= ~d_sync[1];
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx against a clocking PS/2
// device model with ack, nack, silent, glitch and reset cases.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 100;
    localparam int REQ  = 20;
    localparam int FLT  = 8;
    localparam int TO   = 3000;
    localparam int HALF = 40;

    localparam int M_ACK     = 0;
    localparam int M_SILENT  = 1;
    localparam int M_NACK    = 2;
    localparam int M_RESTART = 3;
    localparam int M_RESET   = 4;
    localparam int M_GLITCH  = 5;

    typedef struct packed {
        logic [9:0] frame;
        logic       chk;
        logic       ack;
        logic       tmo;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       c_dev_low = 1'b0;
    logic       d_dev_low = 1'b0;
    logic       ps2c_oe, ps2d_oe;
    logic       c_line, d_line;
    logic [9:0] cap = '0;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   n_stray = 0;
    int   starts = 0;
    int   t_rel = 0;
    exp_t q[$];

    ps2_host_tx_if bus();

    assign c_line = ~(ps2c_oe | c_dev_low);
    assign d_line = ~(ps2d_oe | d_dev_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .REQ_CYCLES     (REQ),
        .FILTER_LEN     (FLT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ps2c_in (c_line),
        .ps2d_in (d_line),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.din   = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        starts++;
    endtask

    task automatic device(input int mode);
        int n;
        cap = '0;
        n = 0;
        while (c_line !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("inhibit_seen", c_line, 0);
        n = 0;
        while (c_line == 1'b0 && d_line == 1'b1 && n < 5 * INH) begin
            @(negedge clk);
            n++;
        end
        check("inhibit_len_ok", n >= INH, 1);
        check("req_under_clk_low", {c_line, d_line}, 2'b00);
        n = 0;
        while (c_line == 1'b0 && n < 5 * REQ) begin
            @(negedge clk);
            n++;
        end
        check("clk_released", {c_line, d_line}, 2'b10);
        t_rel = cyc;
        if (mode == M_SILENT) return;
        repeat (HALF) @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
            c_dev_low = 1'b1;
            for (int k = 0; k < HALF; k++) begin
                if (mode == M_RESET && i == 5 && k == 12) begin
                    rst = 1'b1;
                    @(negedge clk);
                    check("rst_c_oe", ps2c_oe, 0);
                    check("rst_d_oe", ps2d_oe, 0);
                    rst = 1'b0;
                    c_dev_low = 1'b0;
                    return;
                end
                if (mode == M_RESTART && i == 4 && k == 12)
                    bus.din = 8'h00;
                bus.start = (mode == M_RESTART && i == 4 && k == 12);
                @(negedge clk);
            end
            c_dev_low = 1'b0;
            if (i <= 10) cap[i-1] = d_line;
            if (i == 10 && mode != M_NACK) d_dev_low = 1'b1;
            if (i == 11) d_dev_low = 1'b0;
            for (int k = 0; k < HALF; k++) begin
                c_dev_low = (mode == M_GLITCH && i == 3 &&
                             (k == 15 || k == 16));
                @(negedge clk);
            end
            c_dev_low = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] b, input int mode,
                        input exp_t e);
        int d0;
        int n;
        d0 = done_cnt;
        if (mode != M_RESET) q.push_back(e);
        send(b);
        device(mode);
        if (mode == M_RESET) begin
            repeat (TO + 500) @(negedge clk);
            check("no_done_after_rst", done_cnt - d0, 0);
        end else begin
            n = 0;
            while (done_cnt == d0 && n < TO + 2000) begin
                @(negedge clk);
                n++;
            end
            check("done_seen", done_cnt - d0, 1);
        end
        repeat (20) @(negedge clk);
        check("idle_after", bus.busy, 0);
    endtask

    initial begin
        exp_t e;
        int   seen;
        int   bad;
        logic active;
        seen   = 0;
        bad    = 0;
        active = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else begin
                if (starts != seen) begin
                    seen   = starts;
                    active = 1'b1;
                    bad    = 0;
                end
                if (bus.done_tick) begin
                    done_cnt++;
                    if (q.size() == 0) begin
                        n_stray++;
                    end else begin
                        e = q.pop_front();
                        check("ack_ok", bus.ack_ok, e.ack);
                        check("err_timeout", bus.err_timeout, e.tmo);
                        check("done_c_oe", ps2c_oe, 0);
                        check("done_d_oe", ps2d_oe, 0);
                        check("done_busy", bus.busy, 0);
                        check("done_rx_inh", bus.rx_inhibit, 0);
                        check("busy_held", bad, 0);
                        if (e.chk) check("frame", cap, e.frame);
                        if (e.tmo)
                            check("timeout_latency", cyc - t_rel, TO);
                    end
                    active = 1'b0;
                end else if (active &&
                             (!bus.busy || !bus.rx_inhibit)) begin
                    bad++;
                end
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL global_watchdog: got %0d cycles expected finish",
                 cyc);
        $fatal(1, "bench stalled");
    end

    initial begin
        bus.start = 1'b0;
        bus.din   = '0;
        rst       = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_rx_inh", bus.rx_inhibit, 0);
        check("rst_done", bus.done_tick, 0);
        check("rst_ack", bus.ack_ok, 0);
        check("rst_tmo", bus.err_timeout, 0);
        check("rst_c_oe0", ps2c_oe, 0);
        check("rst_d_oe0", ps2d_oe, 0);
        rst = 1'b0;
        repeat (30) @(negedge clk);

        xfer(CMD_SET_LED, M_ACK,     '{10'h3ED, 1'b1, 1'b1, 1'b0});
        xfer(CMD_RESET,   M_ACK,     '{10'h3FF, 1'b1, 1'b1, 1'b0});
        xfer(8'h00,       M_ACK,     '{10'h300, 1'b1, 1'b1, 1'b0});
        xfer(CMD_SET_LED, M_NACK,    '{10'h3ED, 1'b1, 1'b0, 1'b0});
        xfer(CMD_SET_LED, M_RESTART, '{10'h3ED, 1'b1, 1'b1, 1'b0});
        xfer(CMD_SET_LED, M_GLITCH,  '{10'h3ED, 1'b1, 1'b1, 1'b0});
        xfer(8'h5A,       M_SILENT,  '{10'h000, 1'b0, 1'b0, 1'b1});
        xfer(CMD_SET_LED, M_RESET,   '{10'h000, 1'b0, 1'b0, 1'b0});

        check("queue_empty", q.size(), 0);
        check("stray_done", n_stray, 0);
        check("done_total", done_cnt, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
